// File: rtl/flow_control_loop_pipe_sequential_init_if.sv
// Handshake and ROM-port bundle between the parent, the II=1 loop pipeline and the loop adapter.
interface flow_control_loop_pipe_sequential_init_if #(
  parameter int DATA_WIDTH    = 18,
  parameter int ADDRESS_WIDTH = 3
);
  logic                     ap_start;
  logic                     ap_ready;
  logic                     ap_done;
  logic                     ap_start_int;
  logic                     ap_loop_init;
  logic                     ap_ready_int;
  logic                     ap_loop_exit_ready;
  logic                     ap_loop_exit_done;
  logic                     ap_continue_int;
  logic                     ap_done_int;
  logic [ADDRESS_WIDTH-1:0] rom_address0;
  logic                     rom_ce0;
  logic [DATA_WIDTH-1:0]    rom_q0;

  // master: parent + pipeline side driving the adapter
  modport master (
    output ap_start, ap_ready_int, ap_loop_exit_ready, ap_loop_exit_done, ap_done_int,
           rom_address0, rom_ce0,
    input  ap_ready, ap_done, ap_start_int, ap_loop_init, ap_continue_int, rom_q0
  );

  modport slave (
    input  ap_start, ap_ready_int, ap_loop_exit_ready, ap_loop_exit_done, ap_done_int,
           rom_address0, rom_ce0,
    output ap_ready, ap_done, ap_start_int, ap_loop_init, ap_continue_int, rom_q0
  );
endinterface

// File: rtl/flow_control_loop_pipe_sequential_init.sv
// Loop handshake adapter for an II=1 pipelined loop plus its constant ROM (word i = i, out-of-range reads 0).
// Define FLOW_CTRL_ROM_OUTREG_EN to add a ROM output register (read latency 2 instead of 1).
module flow_control_loop_pipe_sequential_init #(
  parameter int DATA_WIDTH    = 18,
  parameter int ADDRESS_RANGE = 6,
  parameter int ADDRESS_WIDTH = 3,
  parameter     INIT_FILE     = ""
) (
  input logic ap_clk,
  input logic ap_rst_n,
  flow_control_loop_pipe_sequential_init_if.slave bus
);

  logic                  loop_init_r;
  logic                  done_cache_r;
  logic [DATA_WIDTH-1:0] rom_q_r;
  logic                  unused_done_int;

  function automatic logic [DATA_WIDTH-1:0] rom_word(input logic [ADDRESS_WIDTH-1:0] a);
    if (int'(a) < ADDRESS_RANGE) rom_word = DATA_WIDTH'(a);
    else                         rom_word = '0;
  endfunction

  assign bus.ap_start_int    = bus.ap_start;
  assign bus.ap_continue_int = 1'b1;
  assign bus.ap_ready        = bus.ap_loop_exit_ready;
  assign bus.ap_loop_init    = loop_init_r & bus.ap_start;
  assign bus.ap_done         = bus.ap_loop_exit_done | done_cache_r;
  assign bus.rom_q0          = rom_q_r;
  assign unused_done_int     = bus.ap_done_int;

  // exit_done takes priority so a back-to-back run restarts with init set
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      loop_init_r  <= 1'b1;
      done_cache_r <= 1'b0;
    end else begin
      if (bus.ap_loop_exit_done) loop_init_r <= 1'b1;
      else if (bus.ap_ready_int) loop_init_r <= 1'b0;

      if (bus.ap_loop_exit_done) done_cache_r <= 1'b1;
      else if (bus.ap_start)     done_cache_r <= 1'b0;
    end
  end

`ifdef FLOW_CTRL_ROM_OUTREG_EN
  logic [DATA_WIDTH-1:0] rom_s1_r;

  // both stages advance only on ce0, so a stalled read holds the whole pipe
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rom_s1_r <= '0;
      rom_q_r  <= '0;
    end else if (bus.rom_ce0) begin
      rom_s1_r <= rom_word(bus.rom_address0);
      rom_q_r  <= rom_s1_r;
    end
  end
`else
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n)        rom_q_r <= '0;
    else if (bus.rom_ce0) rom_q_r <= rom_word(bus.rom_address0);
  end
`endif

endmodule

// File: tb/tb_flow_control_loop_pipe_sequential_init.sv
// Directed bench for the loop handshake adapter and its ROM.
module tb_flow_control_loop_pipe_sequential_init;
`ifdef FLOW_CTRL_ROM_OUTREG_EN
  localparam int ROM_LAT = 2;
`else
  localparam int ROM_LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  flow_control_loop_pipe_sequential_init_if #(.DATA_WIDTH(18), .ADDRESS_WIDTH(3)) bus ();

  flow_control_loop_pipe_sequential_init #(
    .DATA_WIDTH(18), .ADDRESS_RANGE(6), .ADDRESS_WIDTH(3), .INIT_FILE("")
  ) dut (
    .ap_clk  (clk),
    .ap_rst_n(rst_n),
    .bus     (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.ap_start = 1'b1; bus.ap_ready_int = 1'b0; bus.ap_loop_exit_ready = 1'b0;
    bus.ap_loop_exit_done = 1'b0; bus.ap_done_int = 1'b0; bus.rom_address0 = '0; bus.rom_ce0 = 1'b0;
    step(); step();
    #1;
    checks++; if (bus.ap_loop_init !== 1'b1) begin failures++; $display("FAIL reset_loop_init got=%b exp=1", bus.ap_loop_init); end
    checks++; if (bus.ap_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.ap_done); end
    checks++; if (bus.rom_q0 !== 18'd0) begin failures++; $display("FAIL reset_rom_q0 got=%0h exp=0", bus.rom_q0); end
    checks++; if (bus.ap_continue_int !== 1'b1) begin failures++; $display("FAIL reset_continue got=%b exp=1", bus.ap_continue_int); end
    bus.ap_start = 1'b0;
    #1;
    checks++; if (bus.ap_loop_init !== 1'b0) begin failures++; $display("FAIL reset_init_gated got=%b exp=0", bus.ap_loop_init); end
    bus.ap_start = 1'b1;
    rst_n = 1'b1;
  endtask

  // six iterations, init only on the first, ap_ready follows exit_ready combinationally
  task automatic test_run();
    step();
    bus.ap_ready_int = 1'b1;
    #1;
    checks++; if (bus.ap_loop_init !== 1'b1) begin failures++; $display("FAIL run_init_first got=%b exp=1", bus.ap_loop_init); end
    checks++; if (bus.ap_start_int !== 1'b1) begin failures++; $display("FAIL run_start_int got=%b exp=1", bus.ap_start_int); end
    for (int i = 1; i < 6; i++) begin
      step();
      bus.ap_loop_exit_ready = (i == 5);
      #1;
      checks++; if (bus.ap_loop_init !== 1'b0) begin failures++; $display("FAIL run_init_iter%0d got=%b exp=0", i, bus.ap_loop_init); end
      checks++; if (bus.ap_ready !== (i == 5)) begin failures++; $display("FAIL run_ready_iter%0d got=%b exp=%b", i, bus.ap_ready, (i == 5)); end
    end
  endtask

  task automatic test_done_hold();
    step();
    bus.ap_loop_exit_ready = 1'b0; bus.ap_ready_int = 1'b0;
    bus.ap_loop_exit_done = 1'b1; bus.ap_start = 1'b0;
    #1;
    checks++; if (bus.ap_done !== 1'b1) begin failures++; $display("FAIL hold_done_exit got=%b exp=1", bus.ap_done); end
    checks++; if (bus.ap_ready !== 1'b0) begin failures++; $display("FAIL hold_ready_low got=%b exp=0", bus.ap_ready); end
    for (int j = 1; j <= 3; j++) begin
      step();
      bus.ap_loop_exit_done = 1'b0;
      #1;
      checks++; if (bus.ap_done !== 1'b1) begin failures++; $display("FAIL hold_done_c%0d got=%b exp=1", j, bus.ap_done); end
      checks++; if (bus.ap_loop_init !== 1'b0) begin failures++; $display("FAIL hold_init_c%0d got=%b exp=0", j, bus.ap_loop_init); end
    end
    step();
    bus.ap_start = 1'b1; bus.ap_ready_int = 1'b1;
    #1;
    checks++; if (bus.ap_done !== 1'b1) begin failures++; $display("FAIL hold_done_start got=%b exp=1", bus.ap_done); end
    checks++; if (bus.ap_loop_init !== 1'b1) begin failures++; $display("FAIL hold_init_restart got=%b exp=1", bus.ap_loop_init); end
    step();
    bus.ap_ready_int = 1'b0;
    #1;
    checks++; if (bus.ap_done !== 1'b0) begin failures++; $display("FAIL hold_done_drop got=%b exp=0", bus.ap_done); end
    checks++; if (bus.ap_loop_init !== 1'b0) begin failures++; $display("FAIL hold_init_drop got=%b exp=0", bus.ap_loop_init); end
  endtask

  // ap_start stays high; exit_done and ready_int in the same cycle must leave init set
  task automatic test_back_to_back();
    step();
    bus.ap_loop_exit_ready = 1'b1; bus.ap_ready_int = 1'b1;
    #1;
    checks++; if (bus.ap_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready got=%b exp=1", bus.ap_ready); end
    step();
    bus.ap_loop_exit_ready = 1'b0; bus.ap_loop_exit_done = 1'b1;
    #1;
    checks++; if (bus.ap_done !== 1'b1) begin failures++; $display("FAIL b2b_done_exit got=%b exp=1", bus.ap_done); end
    checks++; if (bus.ap_loop_init !== 1'b0) begin failures++; $display("FAIL b2b_init_exit got=%b exp=0", bus.ap_loop_init); end
    step();
    bus.ap_loop_exit_done = 1'b0;
    #1;
    checks++; if (bus.ap_loop_init !== 1'b1) begin failures++; $display("FAIL b2b_init_reassert got=%b exp=1", bus.ap_loop_init); end
    checks++; if (bus.ap_done !== 1'b1) begin failures++; $display("FAIL b2b_done_cached got=%b exp=1", bus.ap_done); end
    step();
    #1;
    checks++; if (bus.ap_loop_init !== 1'b0) begin failures++; $display("FAIL b2b_init_clear got=%b exp=0", bus.ap_loop_init); end
    checks++; if (bus.ap_done !== 1'b0) begin failures++; $display("FAIL b2b_done_clear got=%b exp=0", bus.ap_done); end
    bus.ap_ready_int = 1'b0;
  endtask

  task automatic test_rom();
    logic [2:0]  addrs [5] = '{3'd3, 3'd7, 3'd5, 3'd6, 3'd4};
    logic [17:0] exps  [5] = '{18'd3, 18'd0, 18'd5, 18'd0, 18'd4};
    for (int k = 0; k < 5; k++) begin
      bus.rom_ce0 = 1'b1; bus.rom_address0 = addrs[k];
      for (int c = 0; c < ROM_LAT; c++) step();
      checks++; if (bus.rom_q0 !== exps[k]) begin failures++; $display("FAIL rom_addr%0d got=%0h exp=%0h", addrs[k], bus.rom_q0, exps[k]); end
    end
    bus.rom_ce0 = 1'b0; bus.rom_address0 = 3'd1;
    step(); step(); step();
    checks++; if (bus.rom_q0 !== 18'd4) begin failures++; $display("FAIL rom_hold got=%0h exp=4", bus.rom_q0); end
    bus.rom_ce0 = 1'b1; bus.rom_address0 = 3'd2;
    step();
    checks++; if (bus.rom_q0 !== ((ROM_LAT == 1) ? 18'd2 : 18'd4)) begin failures++; $display("FAIL rom_lat_edge1 got=%0h exp=%0h", bus.rom_q0, (ROM_LAT == 1) ? 18'd2 : 18'd4); end
    step();
    checks++; if (bus.rom_q0 !== 18'd2) begin failures++; $display("FAIL rom_lat_edge2 got=%0h exp=2", bus.rom_q0); end
  endtask

  task automatic test_async_reset();
    step();
    bus.ap_start = 1'b0; bus.ap_loop_exit_done = 1'b1; bus.rom_ce0 = 1'b0;
    step();
    bus.ap_loop_exit_done = 1'b0; bus.ap_ready_int = 1'b1;
    step();
    bus.ap_ready_int = 1'b0; bus.ap_start = 1'b1;
    #1;
    checks++; if (bus.ap_done !== 1'b1) begin failures++; $display("FAIL arst_done_before got=%b exp=1", bus.ap_done); end
    checks++; if (bus.ap_loop_init !== 1'b0) begin failures++; $display("FAIL arst_init_before got=%b exp=0", bus.ap_loop_init); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.ap_done !== 1'b0) begin failures++; $display("FAIL arst_done got=%b exp=0", bus.ap_done); end
    checks++; if (bus.ap_loop_init !== 1'b1) begin failures++; $display("FAIL arst_init got=%b exp=1", bus.ap_loop_init); end
    checks++; if (bus.rom_q0 !== 18'd0) begin failures++; $display("FAIL arst_rom_q0 got=%0h exp=0", bus.rom_q0); end
    #1 rst_n = 1'b1;
    bus.rom_ce0 = 1'b1; bus.rom_address0 = 3'd5;
    for (int c = 0; c < ROM_LAT; c++) step();
    checks++; if (bus.rom_q0 !== 18'd5) begin failures++; $display("FAIL arst_rom_kept got=%0h exp=5", bus.rom_q0); end
    bus.rom_ce0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_run();
    test_done_hold();
    test_back_to_back();
    test_rom();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
